spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave and the single-port RAM, and shares that RAM with a parallel host port.
- Decodes 10-bit SPI command words: rx_data[9:8] is the opcode, rx_data[7:0] is the payload.
- Sequences RAM write and read accesses and returns read bytes on tx_data/tx_valid.
- SPI words cannot be back-pressured, so SPI always has priority. The host uses a req/gnt handshake.

Parameters:
ADDR_WIDTH, 8, RAM address width; SPI address payloads are zero-extended to this width.
AUTO_INC, 0, 1 = SPI write address increments after each SPI write; SPI read address increments after each SPI read (mod 2^ADDR_WIDTH).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
spi_rx_data  input  10  command word from SPI slave
spi_rx_valid  input  1  one-cycle strobe, spi_rx_data valid
spi_tx_data  output  8  read byte to SPI slave
spi_tx_valid  output  1  one-cycle strobe, spi_tx_data valid
host_req  input  1  host access request; hold until host_gnt
host_we  input  1  1 = write, 0 = read; stable while host_req=1
host_addr  input  ADDR_WIDTH  host address; stable while host_req=1
host_wdata  input  8  host write data; stable while host_req=1
host_gnt  output  1  one-cycle pulse; host access is on RAM this cycle
host_rdata  output  8  host read byte
host_rvalid  output  1  one-cycle strobe, host_rdata valid
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  8  RAM write data
ram_rdata  input  8  RAM read data, valid the cycle after ram_en with ram_we=0
busy  output  1  (state != IDLE) or cmd_pend
overflow  output  1  sticky: an SPI word was dropped

Behaviour:
- Reset: all outputs 0; wr_addr=0, rd_addr=0, cmd_pend=0, state=IDLE. Reset mid-access aborts it: no gnt, rvalid or tx_valid after reset. The host must re-request.
- SPI capture: spi_rx_valid loads a 1-deep pending register (cmd_pend=1 at the next edge).
  - If cmd_pend=1 and the word is not consumed in the same cycle: new word dropped, overflow<=1 (cleared only by reset).
  - Consume and arrive in the same cycle: new word accepted.
- Opcodes, decoded from the pending word:
  - 00: wr_addr<=payload. No RAM access, consumed in IDLE in 1 cycle.
  - 10: rd_addr<=payload. No RAM access, consumed in IDLE in 1 cycle.
  - 01: RAM write of payload at wr_addr.
  - 11: RAM read at rd_addr; payload ignored.
- FSM states:
  - IDLE: if cmd_pend, serve SPI. Else if host_req, serve host. Else stay.
  - ACCESS: ram_en=1 for exactly 1 cycle. Writes go to IDLE next; reads go to RD_WAIT.
  - RD_WAIT: capture ram_rdata, then go to IDLE.
- Arbitration: fixed priority, SPI over host, decided only in IDLE. A host access in progress is never preempted.
- Output registers: ram_en/ram_we/ram_addr/ram_wdata are registered and set on the IDLE->ACCESS edge. ram_en, ram_we, host_gnt return to 0 on leaving ACCESS. ram_addr/ram_wdata hold their last value.
- Host grant: host_gnt=1 during the host ACCESS cycle. The host may drop or change req in the cycle after gnt.
- SPI latency: spi_rx_valid at cycle T gives cmd_pend at T+1 and ram_en at T+2.
  - Write complete at end of T+2; AUTO_INC bump of wr_addr at the same edge.
  - Read: ram_rdata valid at T+3; spi_tx_data/spi_tx_valid at T+4.
  - The rd_addr AUTO_INC bump occurs at the same edge as the read's ACCESS cycle.
- Host latency: gnt at cycle C; for reads, host_rdata/host_rvalid at C+2.
- Throughput: write = 2 cycles/access, read = 3 cycles/access (back to IDLE each time).
- Wrap: AUTO_INC address 2^ADDR_WIDTH-1 wraps to 0.
- Read-before-address: opcode 11 with no prior 10 reads address 0 (reset value).
- Host starvation: not possible at the SPI word rate (≥10 clk/word). No fairness logic is required.

Test Plan:
- Reset, then SPI 0x012 (op00, addr 0x12), then 0x1A5 (op01, data 0xA5) -> one cycle with ram_en=1, ram_we=1, ram_addr=0x12, ram_wdata=0xA5, 2 cycles after the second rx_valid; no tx_valid.
- SPI 0x212, then 0x300 with the RAM model returning 0xA5 -> ram_en=1, ram_we=0, ram_addr=0x12 at T+2; spi_tx_data=0xA5, spi_tx_valid=1 at T+4 for exactly 1 cycle.
- host_req write addr 0x40 data 0x3C in the same cycle SPI 0x1FF arrives (wr_addr=0x05) -> SPI write (0x05, 0xFF) goes first; host_gnt follows with ram_addr=0x40, ram_wdata=0x3C; host read of 0x40 then gives host_rvalid with 0x3C at gnt+2.
- AUTO_INC=1: SPI 0x0FE, then three op01 writes (0x11, 0x22, 0x33) -> RAM writes at 0xFE, 0xFF, 0x00 (wrap).
- Two spi_rx_valid on consecutive cycles while FSM is busy with a host read -> second word dropped, overflow=1 and stays 1; first word still executes.
- rst_n low during ACCESS of a host read -> all outputs 0 asynchronously; no host_rvalid after release; the next request is served normally.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between an SPI command stream and a parallel host port.
// SPI words cannot be back-pressured, so SPI always wins arbitration in IDLE.
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter bit AUTO_INC   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            spi_rx_data,
    input  logic                  spi_rx_valid,
    output logic [7:0]            spi_tx_data,
    output logic                  spi_tx_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_gnt,
    output logic [7:0]            host_rdata,
    output logic                  host_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic                  busy,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

    state_t                state, state_d;
    logic                  cmd_pend;
    logic [9:0]            cmd_word;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  serve_host;
    logic                  consume, start_spi, start_host;

    // Opcode bit 8 selects a RAM access (01 write, 11 read); bit 9 picks read/rd_addr.
    always_comb begin
        state_d    = state;
        consume    = 1'b0;
        start_spi  = 1'b0;
        start_host = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_pend) begin
                    consume = 1'b1;
                    if (cmd_word[8]) begin
                        start_spi = 1'b1;
                        state_d   = ACCESS;
                    end
                end else if (host_req) begin
                    start_host = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS:  state_d = ram_we ? IDLE : RD_WAIT;
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_pend     <= 1'b0;
            cmd_word     <= '0;
            overflow     <= 1'b0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            serve_host   <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            host_gnt     <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
        end else begin
            // A word arriving in the cycle the pending one is consumed replaces it.
            if (spi_rx_valid) begin
                if (cmd_pend && !consume) begin
                    overflow <= 1'b1;
                end else begin
                    cmd_word <= spi_rx_data;
                    cmd_pend <= 1'b1;
                end
            end else if (consume) begin
                cmd_pend <= 1'b0;
            end

            if (consume && !cmd_word[8]) begin
                if (cmd_word[9]) rd_addr <= ADDR_WIDTH'(cmd_word[7:0]);
                else             wr_addr <= ADDR_WIDTH'(cmd_word[7:0]);
            end

            spi_tx_valid <= 1'b0;
            host_rvalid  <= 1'b0;

            if (start_spi) begin
                ram_en     <= 1'b1;
                ram_we     <= ~cmd_word[9];
                ram_addr   <= cmd_word[9] ? rd_addr : wr_addr;
                ram_wdata  <= cmd_word[7:0];
                serve_host <= 1'b0;
            end else if (start_host) begin
                ram_en     <= 1'b1;
                ram_we     <= host_we;
                ram_addr   <= host_addr;
                ram_wdata  <= host_wdata;
                host_gnt   <= 1'b1;
                serve_host <= 1'b1;
            end

            if (state == ACCESS) begin
                ram_en   <= 1'b0;
                ram_we   <= 1'b0;
                host_gnt <= 1'b0;
                if (AUTO_INC && !serve_host) begin
                    if (ram_we) wr_addr <= wr_addr + ADDR_WIDTH'(1);
                    else        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                end
            end

            if (state == RD_WAIT) begin
                if (serve_host) begin
                    host_rdata  <= ram_rdata;
                    host_rvalid <= 1'b1;
                end else begin
                    spi_tx_data  <= ram_rdata;
                    spi_tx_valid <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE) || cmd_pend;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench: SPI/host arbitration, latency, overflow, reset abort, AUTO_INC wrap.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] spi_rx_data = '0;
    logic       spi_rx_valid = 1'b0;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       busy, overflow;

    // Second instance with AUTO_INC=1, SPI-only stimulus.
    logic [9:0] s1_rx_data = '0;
    logic       s1_rx_valid = 1'b0;
    logic [7:0] s1_tx_data;
    logic       s1_tx_valid;
    logic       s1_host_req = 1'b0, s1_host_we = 1'b0;
    logic [7:0] s1_host_addr = '0, s1_host_wdata = '0;
    logic       s1_host_gnt, s1_host_rvalid;
    logic [7:0] s1_host_rdata;
    logic       s1_ram_en, s1_ram_we;
    logic [7:0] s1_ram_addr, s1_ram_wdata;
    logic [7:0] s1_ram_rdata = '0;
    logic       s1_busy, s1_overflow;

    logic [7:0] mem [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_WIDTH(8), .AUTO_INC(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .overflow(overflow)
    );

    spi_ram_arbiter #(.ADDR_WIDTH(8), .AUTO_INC(1'b1)) dut_inc (
        .clk(clk), .rst_n(rst_n),
        .spi_rx_data(s1_rx_data), .spi_rx_valid(s1_rx_valid),
        .spi_tx_data(s1_tx_data), .spi_tx_valid(s1_tx_valid),
        .host_req(s1_host_req), .host_we(s1_host_we), .host_addr(s1_host_addr),
        .host_wdata(s1_host_wdata), .host_gnt(s1_host_gnt), .host_rdata(s1_host_rdata),
        .host_rvalid(s1_host_rvalid), .ram_en(s1_ram_en), .ram_we(s1_ram_we),
        .ram_addr(s1_ram_addr), .ram_wdata(s1_ram_wdata), .ram_rdata(s1_ram_rdata),
        .busy(s1_busy), .overflow(s1_overflow)
    );

    // Synchronous single-port RAM model, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word is sampled at the end of the current cycle; returns in cycle T+1.
    task automatic spi_send(input logic [9:0] w);
        spi_rx_data  = w;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    task automatic spi1_send(input logic [9:0] w);
        s1_rx_data  = w;
        s1_rx_valid = 1'b1;
        tick();
        s1_rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        tick(); tick();
        check("rst_ram_en", ram_en, 0);
        check("rst_gnt", host_gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_addr", ram_addr, 0);
        rst_n = 1'b1;
        tick();

        // SPI set write address, then write
        spi_send(10'h012);
        check("t1_pend_busy", busy, 1);
        tick();
        check("t1_op00_no_ram", ram_en, 0);
        spi_send(10'h1A5);
        check("t1_T1_en", ram_en, 0);
        tick();
        check("t1_en", ram_en, 1);
        check("t1_we", ram_we, 1);
        check("t1_addr", ram_addr, 8'h12);
        check("t1_wdata", ram_wdata, 8'hA5);
        check("t1_no_tx", spi_tx_valid, 0);
        tick();
        check("t1_en_off", ram_en, 0);
        check("t1_idle", busy, 0);

        // SPI set read address, then read
        spi_send(10'h212);
        tick();
        spi_send(10'h300);
        tick();
        check("t2_en", ram_en, 1);
        check("t2_we", ram_we, 0);
        check("t2_addr", ram_addr, 8'h12);
        tick();
        check("t2_T3_en", ram_en, 0);
        check("t2_T3_tx", spi_tx_valid, 0);
        tick();
        check("t2_tx_valid", spi_tx_valid, 1);
        check("t2_tx_data", spi_tx_data, 8'hA5);
        tick();
        check("t2_tx_pulse", spi_tx_valid, 0);
        check("t2_idle", busy, 0);

        // SPI pending word beats a simultaneous host request
        spi_send(10'h005);
        tick();
        spi_send(10'h1FF);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h3C;
        tick();
        check("t3_spi_addr", ram_addr, 8'h05);
        check("t3_spi_wdata", ram_wdata, 8'hFF);
        check("t3_spi_no_gnt", host_gnt, 0);
        tick();
        check("t3_gap_gnt", host_gnt, 0);
        tick();
        check("t3_gnt", host_gnt, 1);
        check("t3_h_en", ram_en, 1);
        check("t3_h_we", ram_we, 1);
        check("t3_h_addr", ram_addr, 8'h40);
        check("t3_h_wdata", ram_wdata, 8'h3C);
        host_req = 1'b0;
        tick();
        check("t3_gnt_pulse", host_gnt, 0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        tick();
        check("t3_rd_gnt", host_gnt, 1);
        check("t3_rd_we", ram_we, 0);
        host_req = 1'b0;
        tick();
        check("t3_rd_early", host_rvalid, 0);
        tick();
        check("t3_rvalid", host_rvalid, 1);
        check("t3_rdata", host_rdata, 8'h3C);
        tick();
        check("t3_rvalid_pulse", host_rvalid, 0);

        // Overflow: two SPI words back to back during a host read
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
        tick();
        check("t4_gnt", host_gnt, 1);
        host_req = 1'b0;
        spi_send(10'h012);
        check("t4_no_ovf_yet", overflow, 0);
        spi_send(10'h1BB);
        check("t4_ovf", overflow, 1);
        check("t4_h_rvalid", host_rvalid, 1);
        check("t4_h_rdata", host_rdata, 8'hFF);
        tick();
        check("t4_op00_no_ram", ram_en, 0);
        check("t4_dropped_idle", busy, 0);
        spi_send(10'h1CC);
        tick();
        check("t4_w_addr", ram_addr, 8'h12);
        check("t4_w_wdata", ram_wdata, 8'hCC);
        tick();
        check("t4_ovf_sticky", overflow, 1);

        // Reset during the ACCESS cycle of a host read
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
        tick();
        check("t5_gnt", host_gnt, 1);
        host_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_en", ram_en, 0);
        check("t5_async_gnt", host_gnt, 0);
        check("t5_async_ovf", overflow, 0);
        check("t5_async_addr", ram_addr, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_rvalid", host_rvalid, 0);
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
        tick();
        check("t5_regnt", host_gnt, 1);
        host_req = 1'b0;
        tick(); tick();
        check("t5_rvalid", host_rvalid, 1);
        check("t5_rdata", host_rdata, 8'hCC);

        // Read before any address command uses rd_addr reset value 0
        tick();
        spi_send(10'h300);
        tick();
        check("t6_rd0_addr", ram_addr, 8'h00);
        check("t6_rd0_we", ram_we, 0);
        tick(); tick();
        check("t6_rd0_tx", spi_tx_valid, 1);
        check("t6_rd0_data", spi_tx_data, 8'h00);

        // AUTO_INC write address wrap
        spi1_send(10'h0FE);
        tick();
        spi1_send(10'h111);
        tick();
        check("t7_a0_addr", s1_ram_addr, 8'hFE);
        check("t7_a0_wdata", s1_ram_wdata, 8'h11);
        tick();
        spi1_send(10'h122);
        tick();
        check("t7_a1_addr", s1_ram_addr, 8'hFF);
        check("t7_a1_wdata", s1_ram_wdata, 8'h22);
        tick();
        spi1_send(10'h133);
        tick();
        check("t7_a2_en", s1_ram_en, 1);
        check("t7_a2_addr", s1_ram_addr, 8'h00);
        check("t7_a2_wdata", s1_ram_wdata, 8'h33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
